// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - operation encoding and priority decode shared by pc_unit
// Purpose: one-hot request lines -> single prioritised PC operation.
// Contents: pc_op_e, pc_decode(Up, Branch, Load, Call, Ret).
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Ret > Call > Load > Branch > Up > hold; lower requests are dropped.
  function automatic pc_op_e pc_decode(input logic up, input logic branch,
                                       input logic load, input logic call,
                                       input logic ret);
    pc_op_e op;
    if (ret)         op = PC_RET;
    else if (call)   op = PC_CALL;
    else if (load)   op = PC_LOAD;
    else if (branch) op = PC_BRANCH;
    else if (up)     op = PC_INC;
    else             op = PC_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - LIFO return-address stack for the program counter
// Purpose: holds up to DEPTH return addresses; top of stack is always Dout.
// Ports:
//   Clock, ResetN   clock, async active-low reset (pointer only)
//   Push, Din       push Din when not full
//   Pop             discard top entry when not empty
//   Dout            current top entry (don't-care when empty)
//   Depth           registered count of valid entries
//   Full, Empty     decoded from Depth
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int W     = 7,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Push,
  input  logic          Pop,
  input  logic [W-1:0]  Din,
  output logic [W-1:0]  Dout,
  output logic [DW-1:0] Depth,
  output logic          Full,
  output logic          Empty
);

  // Shift-register organisation: entry 0 is the top, so no read/write
  // pointer indexing is needed and Dout is a plain wire.
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign Full    = (Depth == DW'(DEPTH));
  assign Empty   = (Depth == '0);
  assign do_push = Push && !Full;
  assign do_pop  = Pop && !Empty && !Push;
  assign Dout    = mem[0];

  // Contents are deliberately not reset.
  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem[0] <= Din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)      Depth <= '0;
    else if (do_push) Depth <= Depth + DW'(1);
    else if (do_pop)  Depth <= Depth - DW'(1);
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with call/return stack and sticky stack errors
// Purpose: fetch-stage instruction address generator.
// Ports:
//   Clock, ResetN          clock, async active-low reset
//   Up/Branch/Load/Call/Ret operation requests (prioritised, one per cycle)
//   Offset                 signed branch displacement
//   Target                 absolute address for Load/Call
//   ClearErr               clears Overflow/Underflow
//   Addr                   current program counter
//   Depth, StackFull, StackEmpty  return-stack status
//   Overflow, Underflow    sticky stack error flags
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic                               Clock,
  input  logic                               ResetN,
  input  logic                               Up,
  input  logic                               Branch,
  input  logic [ADDR_W-1:0]                  Offset,
  input  logic                               Load,
  input  logic                               Call,
  input  logic                               Ret,
  input  logic [ADDR_W-1:0]                  Target,
  input  logic                               ClearErr,
  output logic [ADDR_W-1:0]                  Addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   Depth,
  output logic                               StackFull,
  output logic                               StackEmpty,
  output logic                               Overflow,
  output logic                               Underflow
);

  pc_op_e            op;
  logic [ADDR_W-1:0] ret_addr;
  logic              push;
  logic              pop;
  logic              call_err;
  logic              ret_err;

  assign op       = pc_decode(Up, Branch, Load, Call, Ret);
  assign push     = (op == PC_CALL) && !StackFull;
  assign pop      = (op == PC_RET) && !StackEmpty;
  assign call_err = (op == PC_CALL) && StackFull;
  assign ret_err  = (op == PC_RET) && StackEmpty;

  pc_return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .Clock  (Clock),
    .ResetN (ResetN),
    .Push   (push),
    .Pop    (pop),
    .Din    (Addr + ADDR_W'(1)),
    .Dout   (ret_addr),
    .Depth  (Depth),
    .Full   (StackFull),
    .Empty  (StackEmpty)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Addr <= RESET_ADDR;
    end else begin
      unique case (op)
        PC_INC:    Addr <= Addr + ADDR_W'(1);
        // Offset is already ADDR_W wide, so a plain modular add equals
        // adding its sign extension.
        PC_BRANCH: Addr <= Addr + Offset;
        PC_LOAD:   Addr <= Target;
        PC_CALL:   if (push) Addr <= Target;
        PC_RET:    if (pop)  Addr <= ret_addr;
        default:   Addr <= Addr;
      endcase
    end
  end

  // A new error in the same cycle as ClearErr keeps the flag set.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= call_err || (Overflow && !ClearErr);
      Underflow <= ret_err  || (Underflow && !ClearErr);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a queue-based model
module tb_pc_unit;
  localparam int AW  = 7;
  localparam int SD  = 4;
  localparam int DW  = $clog2(SD + 1);
  localparam int MOD = 2 ** AW;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          Up = 1'b0, Branch = 1'b0, Load = 1'b0, Call = 1'b0, Ret = 1'b0, ClearErr = 1'b0;
  logic [AW-1:0] Offset = '0, Target = '0;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Depth;
  logic          StackFull, StackEmpty, Overflow, Underflow;

  int checks = 0;
  int errors = 0;

  int m_addr;
  int m_stack[$];
  bit m_ovf, m_unf;

  always #5 Clock = ~Clock;

  pc_unit #(.ADDR_W(AW), .RESET_ADDR(7'd0), .STACK_DEPTH(SD)) dut (
    .Clock(Clock), .ResetN(ResetN), .Up(Up), .Branch(Branch), .Offset(Offset),
    .Load(Load), .Call(Call), .Ret(Ret), .Target(Target), .ClearErr(ClearErr),
    .Addr(Addr), .Depth(Depth), .StackFull(StackFull), .StackEmpty(StackEmpty),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  task automatic model_reset();
    m_addr = 0;
    m_stack.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    @(posedge Clock); #1;
    ResetN = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of requests, let the edge happen, then advance the model.
  task automatic cycle(input bit up, input bit br, input bit ld, input bit cl,
                       input bit rt, input bit clr, input logic [AW-1:0] off,
                       input logic [AW-1:0] tgt);
    bit new_ovf, new_unf;
    int so;
    Up = up; Branch = br; Load = ld; Call = cl; Ret = rt; ClearErr = clr;
    Offset = off; Target = tgt;
    @(posedge Clock); #1;
    Up = 0; Branch = 0; Load = 0; Call = 0; Ret = 0; ClearErr = 0;
    new_ovf = 0;
    new_unf = 0;
    if (rt) begin
      if (m_stack.size() == 0) new_unf = 1;
      else m_addr = m_stack.pop_back();
    end else if (cl) begin
      if (m_stack.size() == SD) new_ovf = 1;
      else begin
        m_stack.push_back((m_addr + 1) % MOD);
        m_addr = int'(tgt);
      end
    end else if (ld) begin
      m_addr = int'(tgt);
    end else if (br) begin
      so = (int'(off) >= MOD / 2) ? int'(off) - MOD : int'(off);
      m_addr = ((m_addr + so) % MOD + MOD) % MOD;
    end else if (up) begin
      m_addr = (m_addr + 1) % MOD;
    end
    m_ovf = new_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = new_unf ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      Up = (i % 2 == 0);
      @(posedge Clock); #1;
    end
    Up = 0;
    checks++; if (Addr !== 7'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", Addr); end
    checks++; if (Depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", Depth); end
    checks++; if (StackEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", StackEmpty); end
    checks++; if ({StackFull, Overflow, Underflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {StackFull, Overflow, Underflow}); end
    ResetN = 1'b1;
    for (int i = 0; i < 37; i++) cycle(1, 0, 0, 0, 0, 0, '0, '0);
    checks++; if (Addr !== 7'd37) begin errors++; $display("FAIL count_to_37: got %0d expected 37", Addr); end
    #2 ResetN = 1'b0;
    #1;
    checks++; if (Addr !== 7'd0) begin errors++; $display("FAIL async_reset_addr: got %0d expected 0", Addr); end
    @(posedge Clock); #1;
    ResetN = 1'b1;
    model_reset();
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 130; i++) begin
      cycle(1, 0, 0, 0, 0, 0, '0, '0);
      checks++;
      if (int'(Addr) !== (i + 1) % MOD) begin
        errors++; $display("FAIL count_wrap step %0d: got %0d expected %0d", i, Addr, (i + 1) % MOD);
      end
    end
  endtask

  task automatic test_branch();
    cycle(0, 0, 1, 0, 0, 0, '0, 7'd5);
    cycle(0, 1, 0, 0, 0, 0, 7'h7D, '0);
    checks++; if (Addr !== 7'd2) begin errors++; $display("FAIL branch_back: got %0d expected 2", Addr); end
    cycle(0, 0, 1, 0, 0, 0, '0, 7'd126);
    cycle(0, 1, 0, 0, 0, 0, 7'd4, '0);
    checks++; if (Addr !== 7'd2) begin errors++; $display("FAIL branch_wrap: got %0d expected 2", Addr); end
  endtask

  task automatic test_call_ret();
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, '0, 7'd10);
    cycle(0, 0, 0, 1, 0, 0, '0, 7'd40);
    checks++; if (Addr !== 7'd40 || Depth !== 3'd1) begin errors++; $display("FAIL call: got addr %0d depth %0d expected 40 1", Addr, Depth); end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, '0, '0);
    checks++; if (Addr !== 7'd43) begin errors++; $display("FAIL up_after_call: got %0d expected 43", Addr); end
    cycle(0, 0, 0, 0, 1, 0, '0, '0);
    checks++; if (Addr !== 7'd11 || Depth !== 3'd0 || StackEmpty !== 1'b1) begin errors++; $display("FAIL ret: got addr %0d depth %0d expected 11 0", Addr, Depth); end
  endtask

  task automatic test_stack_limits();
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, '0, 7'd20);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0, 0, '0, 7'(50 + 10 * i));
      checks++;
      if (int'(Addr) !== m_addr || int'(Depth) !== m_stack.size()) begin
        errors++; $display("FAIL call_%0d: got addr %0d depth %0d expected %0d %0d", i, Addr, Depth, m_addr, m_stack.size());
      end
    end
    checks++; if (Addr !== 7'd80 || StackFull !== 1'b1 || Overflow !== 1'b1) begin errors++; $display("FAIL overflow: got addr %0d full %0b ovf %0b expected 80 1 1", Addr, StackFull, Overflow); end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1, 0, '0, '0);
      checks++;
      if (int'(Addr) !== m_addr || int'(Depth) !== m_stack.size()) begin
        errors++; $display("FAIL ret_%0d: got addr %0d depth %0d expected %0d %0d", i, Addr, Depth, m_addr, m_stack.size());
      end
    end
    checks++; if (Addr !== 7'd21 || Underflow !== 1'b1 || StackEmpty !== 1'b1) begin errors++; $display("FAIL underflow: got addr %0d unf %0b expected 21 1", Addr, Underflow); end
    cycle(0, 0, 0, 0, 1, 1, '0, '0);
    checks++; if (Underflow !== 1'b1 || Overflow !== 1'b0) begin errors++; $display("FAIL clear_vs_set: got unf %0b ovf %0b expected 1 0", Underflow, Overflow); end
    cycle(0, 0, 0, 0, 0, 1, '0, '0);
    checks++; if (Underflow !== 1'b0 || Overflow !== 1'b0) begin errors++; $display("FAIL clear_err: got unf %0b ovf %0b expected 0 0", Underflow, Overflow); end
  endtask

  task automatic test_priority();
    do_reset();
    cycle(0, 0, 1, 0, 0, 0, '0, 7'd30);
    cycle(0, 0, 0, 1, 0, 0, '0, 7'd60);
    cycle(1, 0, 0, 1, 1, 0, '0, 7'd100);
    checks++; if (Addr !== 7'd31 || Depth !== 3'd0) begin errors++; $display("FAIL prio_ret: got addr %0d depth %0d expected 31 0", Addr, Depth); end
    cycle(1, 0, 1, 0, 0, 0, '0, 7'd9);
    checks++; if (Addr !== 7'd9) begin errors++; $display("FAIL prio_load: got %0d expected 9", Addr); end
    cycle(1, 1, 0, 0, 0, 0, 7'd3, '0);
    checks++; if (Addr !== 7'd12) begin errors++; $display("FAIL prio_branch: got %0d expected 12", Addr); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
            7'($urandom), 7'($urandom));
      checks++;
      if (int'(Addr) !== m_addr || int'(Depth) !== m_stack.size() ||
          StackFull !== (m_stack.size() == SD) || StackEmpty !== (m_stack.size() == 0) ||
          Overflow !== m_ovf || Underflow !== m_unf) begin
        errors++;
        $display("FAIL random cycle %0d: got addr %0d depth %0d ovf %0b unf %0b expected %0d %0d %0b %0b",
                 i, Addr, Depth, Overflow, Underflow, m_addr, m_stack.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_branch();
    test_call_ret();
    test_stack_limits();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
